wb_alu_coproc: RTL

Parametrised successor to the Wishbone shift/logic coprocessor. It is a Wishbone-classic slave holding two operand registers and a command register. Shift and logic operations complete in one cycle; unsigned multiply and divide run as iterative multi-cycle operations. The block reports busy, done and divide-by-zero status, produces a double-width result (product high word, or remainder), and raises an optional level interrupt on completion.

---
 rtl/wb_coproc_pkg.sv | 41 ++++
 rtl/wb_coproc_muldiv.sv | 108 ++++++++++
 rtl/wb_alu_coproc.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_coproc_pkg.sv
// ----------------------------------------------------------------------------
// wb_coproc_pkg
// Shared definitions for the Wishbone ALU coprocessor: op codes, register word
// indices, CTRL/STATUS bit positions and the control FSM state encoding.
// ----------------------------------------------------------------------------
package wb_coproc_pkg;

    // Operation codes written to CTRL[2:0]
    localparam logic [2:0] OP_SLL  = 3'd0;
    localparam logic [2:0] OP_SRL  = 3'd1;
    localparam logic [2:0] OP_SRA  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_MULU = 3'd6;
    localparam logic [2:0] OP_DIVU = 3'd7;

    // Register word indices (byte address bits [4:2])
    localparam logic [2:0] REG_OPA    = 3'd0;
    localparam logic [2:0] REG_OPB    = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_RES_LO = 3'd3;
    localparam logic [2:0] REG_RES_HI = 3'd4;

    // STATUS read-back bit positions
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_DZ   = 2;
    localparam int unsigned STAT_IE   = 8;

    // CTRL write bit positions
    localparam int unsigned CTRL_IE = 8;

    // Control FSM
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        DONE_ST = 2'd2
    } state_e;

endpackage

// File: rtl/wb_coproc_muldiv.sv
// ----------------------------------------------------------------------------
// wb_coproc_muldiv
// Iterative unsigned multiply (shift-add, LSB first) and restoring divide, one
// bit per cycle, XLEN iterations. Divide by zero finishes after one cycle with
// lo = all ones, hi = dividend.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_start          pulse: latch operands and begin (ignored while busy)
//   i_div            1 = divide, 0 = multiply (sampled with i_start)
//   i_a, i_b         operands (multiplicand/multiplier, dividend/divisor)
//   o_busy           an operation is in flight
//   o_done           combinational: this cycle's edge completes the operation
//   o_dz             completing operation was a divide by zero
//   o_hi, o_lo       final result, valid while o_done (product, or rem/quot)
// ----------------------------------------------------------------------------
module wb_coproc_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_div,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_dz,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    localparam int unsigned     SHW      = $clog2(XLEN);
    localparam logic [SHW-1:0]  LAST_CNT = SHW'(XLEN - 1);

    logic            r_run;
    logic            r_div;
    logic            r_dz;
    logic [SHW-1:0]  r_cnt;
    // r_acc: product high half / partial remainder
    // r_q:   multiplier being consumed into product low half / dividend -> quotient
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_b;

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_acc_next;
    logic [XLEN-1:0] w_q_next;

    always_comb begin
        w_sum  = {1'b0, r_acc} + ({(XLEN+1){r_q[0]}} & {1'b0, r_b});
        w_rem  = {r_acc, r_q[XLEN-1]};
        w_diff = w_rem - {1'b0, r_b};
        if (r_div) begin
            // Borrow out of the top bit means the trial subtraction failed
            if (!w_diff[XLEN]) begin
                w_acc_next = w_diff[XLEN-1:0];
                w_q_next   = {r_q[XLEN-2:0], 1'b1};
            end else begin
                w_acc_next = w_rem[XLEN-1:0];
                w_q_next   = {r_q[XLEN-2:0], 1'b0};
            end
        end else begin
            w_acc_next = w_sum[XLEN:1];
            w_q_next   = {w_sum[0], r_q[XLEN-1:1]};
        end
    end

    always_comb begin
        o_busy = r_run;
        o_dz   = r_dz;
        o_done = r_run & (r_dz | (r_cnt == LAST_CNT));
        o_lo   = r_dz ? '1  : w_q_next;
        o_hi   = r_dz ? r_q : w_acc_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_div <= 1'b0;
            r_dz  <= 1'b0;
            r_cnt <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_b   <= '0;
        end else if (i_start && !r_run) begin
            r_run <= 1'b1;
            r_div <= i_div;
            r_dz  <= i_div & (i_b == '0);
            r_cnt <= '0;
            r_acc <= '0;
            r_q   <= i_a;
            r_b   <= i_b;
        end else if (r_run) begin
            if (o_done) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_acc_next;
                r_q   <= w_q_next;
            end
        end
    end

endmodule

// File: rtl/wb_alu_coproc.sv
// ----------------------------------------------------------------------------
// wb_alu_coproc
// Wishbone-classic ALU coprocessor: two operand registers, a command register,
// single-cycle shift/logic ops and an iterative multiply/divide engine.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   adr_i[4:0]   byte address, word select = adr_i[4:2]
//   dat_i        write data
//   we_i         write enable
//   stb_i, cyc_i Wishbone strobe / cycle
//   dat_o        registered read data
//   ack_o        one-cycle acknowledge per accepted access
//   irq_o        completion interrupt, level = done & ie
// ----------------------------------------------------------------------------
module wb_alu_coproc
    import wb_coproc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      adr_i,
    input  logic [XLEN-1:0] dat_i,
    input  logic            we_i,
    input  logic            stb_i,
    input  logic            cyc_i,
    output logic [XLEN-1:0] dat_o,
    output logic            ack_o,
    output logic            irq_o
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_e          r_state;
    state_e          w_state_next;

    logic [XLEN-1:0] r_opa;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_res_lo;
    logic [XLEN-1:0] r_res_hi;
    logic [XLEN-1:0] r_dat;
    logic [2:0]      r_op;
    logic            r_ack;
    logic            r_busy;
    logic            r_done;
    logic            r_dz;
    logic            r_ie;

    logic [2:0]      w_word;
    logic            w_acc;
    logic            w_ctrl_wr;
    logic            w_ctrl_ie;
    logic            w_start;
    logic            w_eng_start;
    logic            w_finish;
    logic            w_iter_op;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_status;
    logic [15:0]     w_stat_wide;

    logic            w_eng_busy;
    logic            w_eng_done;
    logic            w_eng_dz;
    logic [XLEN-1:0] w_eng_hi;
    logic [XLEN-1:0] w_eng_lo;
    logic            w_unused;

    assign w_word    = adr_i[4:2];
    assign w_acc     = cyc_i & stb_i & ~r_ack;
    assign w_ctrl_wr = w_acc & we_i & (w_word == REG_CTRL) & ~r_busy;
    assign w_iter_op = (r_op == OP_MULU) | (r_op == OP_DIVU);
    assign w_unused  = ^{adr_i[1:0], w_eng_busy};

    // Narrow datapaths have no room for the ie bit on the bus
    if (XLEN > CTRL_IE) begin : g_ctrl_ie
        assign w_ctrl_ie = dat_i[CTRL_IE];
    end else begin : g_no_ctrl_ie
        assign w_ctrl_ie = 1'b0;
    end

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_SLL:  w_alu = r_opa << r_opb[SHW-1:0];
            OP_SRL:  w_alu = r_opa >> r_opb[SHW-1:0];
            OP_SRA:  w_alu = $unsigned($signed(r_opa) >>> r_opb[SHW-1:0]);
            OP_AND:  w_alu = r_opa & r_opb;
            OP_OR:   w_alu = r_opa | r_opb;
            OP_XOR:  w_alu = r_opa ^ r_opb;
            default: w_alu = '0;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_ctrl_wr) w_state_next = CALC;
            CALC:    if (w_finish)  w_state_next = IDLE;
            DONE_ST: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_start     = 1'b0;
        w_eng_start = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                w_start     = w_ctrl_wr;
                w_eng_start = w_ctrl_wr &
                              ((dat_i[2:0] == OP_MULU) | (dat_i[2:0] == OP_DIVU));
            end
            CALC: w_finish = w_iter_op ? w_eng_done : 1'b1;
            default: ;
        endcase
    end

    wb_coproc_muldiv #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_eng_start),
        .i_div   (dat_i[2:0] == OP_DIVU),
        .i_a     (r_opa),
        .i_b     (r_opb),
        .o_busy  (w_eng_busy),
        .o_done  (w_eng_done),
        .o_dz    (w_eng_dz),
        .o_hi    (w_eng_hi),
        .o_lo    (w_eng_lo)
    );

    // ---------------- read mux ----------------
    always_comb begin
        w_stat_wide            = '0;
        w_stat_wide[STAT_BUSY] = r_busy;
        w_stat_wide[STAT_DONE] = r_done;
        w_stat_wide[STAT_DZ]   = r_dz;
        w_stat_wide[STAT_IE]   = r_ie;
        w_status               = XLEN'(w_stat_wide);
        case (w_word)
            REG_OPA:    w_rdata = r_opa;
            REG_OPB:    w_rdata = r_opb;
            REG_CTRL:   w_rdata = w_status;
            REG_RES_LO: w_rdata = r_res_lo;
            REG_RES_HI: w_rdata = r_res_hi;
            default:    w_rdata = '0;
        endcase
    end

    // ---------------- bus and register file ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_op     <= OP_SLL;
            r_ie     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_acc) begin
                r_dat <= w_rdata;
            end
            if (w_acc && we_i && !r_busy) begin
                if (w_word == REG_OPA) r_opa <= dat_i;
                if (w_word == REG_OPB) r_opb <= dat_i;
            end
            if (w_start) begin
                r_op   <= dat_i[2:0];
                r_ie   <= w_ctrl_ie;
                r_busy <= 1'b1;
                r_done <= 1'b0;
                r_dz   <= 1'b0;
            end else if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                if (w_iter_op) begin
                    r_res_lo <= w_eng_lo;
                    r_res_hi <= w_eng_hi;
                    r_dz     <= w_eng_dz;
                end else begin
                    r_res_lo <= w_alu;
                    r_res_hi <= '0;
                end
            end
        end
    end

    assign dat_o = r_dat;
    assign ack_o = r_ack;
    assign irq_o = r_done & r_ie;

endmodule
